// File: rtl/neo_pkg.sv
// Shared NeoPixel link definitions: receiver FSM states and 50 MHz strand timing,
// used by the strand controller, this receiver and its bench.
package neo_pkg;

   typedef enum logic [1:0] {
      WAIT_GAP = 2'd0,
      LOW      = 2'd1,
      HIGH     = 2'd2
   } neo_rx_state_t;

   localparam int T0H     = 18;
   localparam int T1H     = 35;
   localparam int T_BIT   = 63;
   localparam int T_LATCH = 2500;

endpackage

// File: rtl/neo_sync.sv
// Two-flop synchronizer for the raw serial line plus rise/fall detect on the synced level.
// Latency 2 clocks to s; rise/fall are combinational from s vs its delayed copy.
module neo_sync (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic s,
   output logic rise,
   output logic fall
);

   logic meta;
   logic s_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         s    <= 1'b0;
         s_d  <= 1'b0;
      end else begin
         meta <= din;
         s    <= meta;
         s_d  <= s;
      end
   end

   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

endmodule

// File: rtl/neo_pixel_receiver.sv
// Decodes a WS2812 one-wire stream into GRB pixels by timing each high pulse.
// pixel_valid lands 3 clocks after the raw fall of bit 24; no backpressure, pulses are fire-and-forget.
module neo_pixel_receiver
   import neo_pkg::*;
#(
   parameter int THRESH_CYCLES = 26,
   parameter int MIN_HIGH      = 8,
   parameter int MAX_HIGH      = 60,
   parameter int LATCH_CYCLES  = 2500,
   parameter int NUM_PIXELS    = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        neo_data,
   output logic [23:0] color_grb,
   output logic [2:0]  pixel_index,
   output logic        pixel_valid,
   output logic        frame_done,
   output logic        bit_error,
   output logic        overflow
);

   localparam int CW = $clog2(LATCH_CYCLES + 1);
   localparam logic [CW-1:0] LATCH_END = CW'(LATCH_CYCLES - 1);
   localparam logic [CW-1:0] HI_MAX    = CW'(MAX_HIGH);
   localparam logic [CW-1:0] HI_MIN    = CW'(MIN_HIGH);
   localparam logic [CW-1:0] HI_THR    = CW'(THRESH_CYCLES);
   localparam logic [2:0]    PIX_MAX   = 3'(NUM_PIXELS);

   logic s, rise, fall;

   neo_sync u_sync (
      .clock (clock),
      .reset (reset),
      .din   (neo_data),
      .s     (s),
      .rise  (rise),
      .fall  (fall)
   );

   neo_rx_state_t state, state_nxt;
   logic [CW-1:0] low_cnt, high_cnt;
   logic [4:0]    bit_cnt;
   logic [23:0]   shift_reg;
   logic [2:0]    pix_cnt;

   logic ev_bit, ev_err, ev_latch, bit_val;
   logic word_done, valid_nxt, ovf_nxt, frame_nxt, err_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= WAIT_GAP;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ev_bit    = 1'b0;
      ev_err    = 1'b0;
      ev_latch  = 1'b0;
      bit_val   = (high_cnt >= HI_THR);
      case (state)
         WAIT_GAP: if (!s && low_cnt == LATCH_END) state_nxt = LOW;
         LOW: begin
            if (rise)                       state_nxt = HIGH;
            else if (low_cnt == LATCH_END)  ev_latch  = 1'b1;
         end
         HIGH: begin
            // Width reaching MAX_HIGH is stuck-high even if the fall arrives that same cycle.
            if (high_cnt == HI_MAX || (fall && high_cnt < HI_MIN)) begin
               ev_err    = 1'b1;
               state_nxt = WAIT_GAP;
            end else if (fall) begin
               ev_bit    = 1'b1;
               state_nxt = LOW;
            end
         end
         default: state_nxt = WAIT_GAP;
      endcase
   end

   always_comb begin
      word_done = ev_bit && (bit_cnt == 5'd23);
      valid_nxt = word_done && (pix_cnt < PIX_MAX);
      ovf_nxt   = word_done && !(pix_cnt < PIX_MAX);
      frame_nxt = ev_latch && (bit_cnt != 5'd0 || pix_cnt != 3'd0);
      err_nxt   = ev_err || (ev_latch && bit_cnt != 5'd0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         low_cnt     <= '0;
         high_cnt    <= '0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         pix_cnt     <= '0;
         color_grb   <= '0;
         pixel_index <= '0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         bit_error   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pixel_valid <= valid_nxt;
         frame_done  <= frame_nxt;
         bit_error   <= err_nxt;
         overflow    <= ovf_nxt;
         case (state)
            WAIT_GAP: begin
               // Hold the frame state empty so decoding restarts cleanly at pixel 0.
               low_cnt   <= (s || low_cnt == LATCH_END) ? '0 : low_cnt + 1'b1;
               bit_cnt   <= '0;
               shift_reg <= '0;
               pix_cnt   <= '0;
            end
            LOW: begin
               if (rise) begin
                  high_cnt <= CW'(1);
                  low_cnt  <= '0;
               end else if (ev_latch) begin
                  low_cnt   <= '0;
                  bit_cnt   <= '0;
                  shift_reg <= '0;
                  pix_cnt   <= '0;
               end else begin
                  low_cnt <= low_cnt + 1'b1;
               end
            end
            HIGH: begin
               if (ev_err) begin
                  low_cnt <= '0;
               end else if (ev_bit) begin
                  shift_reg <= {shift_reg[22:0], bit_val};
                  bit_cnt   <= word_done ? 5'd0 : bit_cnt + 5'd1;
                  low_cnt   <= '0;
               end else if (high_cnt != HI_MAX) begin
                  high_cnt <= high_cnt + 1'b1;
               end
            end
            default: low_cnt <= '0;
         endcase
         if (valid_nxt) begin
            color_grb   <= {shift_reg[22:0], bit_val};
            pixel_index <= pix_cnt;
            pix_cnt     <= pix_cnt + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_neo_pixel_receiver.sv
// Directed bench for neo_pixel_receiver: table of pixels per frame plus hand-written
// sequences for partial frames, glitches and stuck-high lines.
module tb_neo_pixel_receiver;
   import neo_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        neo_data;
   logic [23:0] color_grb;
   logic [2:0]  pixel_index;
   logic        pixel_valid, frame_done, bit_error, overflow;

   neo_pixel_receiver dut (
      .clock       (clock),
      .reset       (reset),
      .neo_data    (neo_data),
      .color_grb   (color_grb),
      .pixel_index (pixel_index),
      .pixel_valid (pixel_valid),
      .frame_done  (frame_done),
      .bit_error   (bit_error),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_fall_cyc = 0;

   int          n_valid = 0, n_fd = 0, n_be = 0, n_ovf = 0;
   int          valid_cyc = 0, fd_cyc = 0, be_cyc = 0;
   logic [23:0] last_color = '0;
   logic [2:0]  last_idx = '0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset) begin
         if (pixel_valid) begin
            n_valid++;
            valid_cyc  = cyc;
            last_color = color_grb;
            last_idx   = pixel_index;
         end
         if (frame_done) begin n_fd++;  fd_cyc = cyc; end
         if (bit_error)  begin n_be++;  be_cyc = cyc; end
         if (overflow)   n_ovf++;
      end
   end

   typedef struct {
      logic [23:0] pix;
      logic        exp_valid;
      logic        exp_ovf;
      logic [23:0] exp_color;
      logic [2:0]  exp_idx;
      logic        latch;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      int h;
      h = b ? T1H : T0H;
      neo_data = 1'b1;
      repeat (h) tick();
      neo_data = 1'b0;
      last_fall_cyc = cyc;
      repeat (T_BIT - h) tick();
   endtask

   task automatic send_bits(input logic [23:0] v, input int n);
      for (int i = 23; i > 23 - n; i--) send_bit(v[i]);
   endtask

   task automatic idle(input int n);
      neo_data = 1'b0;
      repeat (n) tick();
   endtask

   int v0, f0, b0, o0, rise_cyc;

   initial begin
      vecs[0]  = '{24'h000001, 1'b1, 1'b0, 24'h000001, 3'd0, 1'b0};
      vecs[1]  = '{24'h000002, 1'b1, 1'b0, 24'h000002, 3'd1, 1'b0};
      vecs[2]  = '{24'h000003, 1'b1, 1'b0, 24'h000003, 3'd2, 1'b0};
      vecs[3]  = '{24'h000004, 1'b1, 1'b0, 24'h000004, 3'd3, 1'b0};
      vecs[4]  = '{24'h000005, 1'b1, 1'b0, 24'h000005, 3'd4, 1'b1};
      vecs[5]  = '{24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF, 3'd0, 1'b0};
      vecs[6]  = '{24'h800001, 1'b1, 1'b0, 24'h800001, 3'd1, 1'b0};
      vecs[7]  = '{24'h123456, 1'b1, 1'b0, 24'h123456, 3'd2, 1'b0};
      vecs[8]  = '{24'hA5A5A5, 1'b1, 1'b0, 24'hA5A5A5, 3'd3, 1'b0};
      vecs[9]  = '{24'h0F0F0F, 1'b1, 1'b0, 24'h0F0F0F, 3'd4, 1'b0};
      vecs[10] = '{24'hDEADBE, 1'b0, 1'b1, 24'h0F0F0F, 3'd4, 1'b1};

      reset    = 1'b1;
      neo_data = 1'b0;
      repeat (3) tick();
      check("reset_color", 32'(color_grb), 32'h0);
      check("reset_index", 32'(pixel_index), 32'h0);
      check("reset_pulses", 32'({pixel_valid, frame_done, bit_error, overflow}), 32'h0);
      check("reset_state", 32'(dut.state), 32'(WAIT_GAP));
      reset = 1'b0;
      idle(2600);

      // Single pixel, latency from raw fall of the 24th bit
      v0 = n_valid; f0 = n_fd;
      send_bits(24'h00FF00, 24);
      check("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
      check("t1_color", 32'(last_color), 32'h00FF00);
      check("t1_index", 32'(last_idx), 32'd0);
      check("t1_latency", 32'(valid_cyc - last_fall_cyc), 32'd3);
      idle(2600);
      check("t1_frame_done", 32'(n_fd - f0), 32'd1);

      // Table-driven frames: 5 pixels, then 6 pixels with overflow on the last
      for (int r = 0; r < 11; r++) begin
         v0 = n_valid; o0 = n_ovf; f0 = n_fd; b0 = n_be;
         send_bits(vecs[r].pix, 24);
         check($sformatf("row%0d_valid", r), 32'(n_valid - v0), 32'(vecs[r].exp_valid));
         check($sformatf("row%0d_ovf", r), 32'(n_ovf - o0), 32'(vecs[r].exp_ovf));
         check($sformatf("row%0d_color", r), 32'(color_grb), 32'(vecs[r].exp_color));
         check($sformatf("row%0d_index", r), 32'(pixel_index), 32'(vecs[r].exp_idx));
         if (vecs[r].exp_valid)
            check($sformatf("row%0d_latency", r), 32'(valid_cyc - last_fall_cyc), 32'd3);
         if (vecs[r].latch) begin
            idle(2600);
            check($sformatf("row%0d_fd", r), 32'(n_fd - f0), 32'd1);
            check($sformatf("row%0d_fd_lat", r), 32'(fd_cyc - last_fall_cyc), 32'd2503);
         end
         check($sformatf("row%0d_no_err", r), 32'(n_be - b0), 32'd0);
      end

      // Partial pixel at latch: frame_done and bit_error together
      v0 = n_valid; f0 = n_fd; b0 = n_be;
      send_bits(24'hC3A500, 12);
      idle(2600);
      check("t3_no_valid", 32'(n_valid - v0), 32'd0);
      check("t3_fd", 32'(n_fd - f0), 32'd1);
      check("t3_be", 32'(n_be - b0), 32'd1);
      check("t3_same_cycle", 32'(fd_cyc - be_cyc), 32'd0);

      // Glitch at bit 7, trailing bits ignored, recovery at pixel 0
      v0 = n_valid; f0 = n_fd; b0 = n_be;
      send_bits(24'hAAAAAA, 7);
      neo_data = 1'b1;
      repeat (4) tick();
      idle(59);
      send_bits(24'hFFFFFF, 16);
      check("t4_be", 32'(n_be - b0), 32'd1);
      check("t4_no_valid", 32'(n_valid - v0), 32'd0);
      idle(2600);
      check("t4_no_fd", 32'(n_fd - f0), 32'd0);
      send_bits(24'h3C00C3, 24);
      check("t4_valid", 32'(n_valid - v0), 32'd1);
      check("t4_color", 32'(last_color), 32'h3C00C3);
      check("t4_index", 32'(last_idx), 32'd0);
      idle(2600);
      check("t4_fd", 32'(n_fd - f0), 32'd1);

      // Stuck-high line
      b0 = n_be; f0 = n_fd;
      neo_data = 1'b1;
      rise_cyc = cyc;
      repeat (100) tick();
      check("t5_be", 32'(n_be - b0), 32'd1);
      check("t5_be_time", 32'(be_cyc - rise_cyc), 32'd63);
      check("t5_state", 32'(dut.state), 32'(WAIT_GAP));
      idle(2600);
      check("t5_no_fd", 32'(n_fd - f0), 32'd0);

      // Asynchronous reset clears held outputs without a clock edge
      #2;
      reset = 1'b1;
      #1;
      check("arst_color", 32'(color_grb), 32'h0);
      check("arst_index", 32'(pixel_index), 32'h0);
      tick();
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
